// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and helpers for the pc_sequencer block.
// Optional build macro used by pc_sequencer: PC_SEQ_SINGLE_STEP_EN.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    // Phase bit indices; the commit phase is always the MSB of the phase vector.
    localparam int PH_FETCH = 0;

    // Widest PC the helper below can handle.
    localparam int MAX_W = 64;

    // Sign-extend an off_w-bit instruction offset and scale it to a byte offset.
    function automatic logic [MAX_W-1:0] sext_shift(input logic [MAX_W-1:0] off,
                                                    input int               off_w,
                                                    input int               shift);
        logic [MAX_W-1:0] t;
        t = off << (MAX_W - off_w);
        t = $signed(t) >>> (MAX_W - off_w);
        return t << shift;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with occupancy counter.
// A push while full overwrites the oldest entry; a pop while empty leaves the
// stack untouched. Both cases are reported as single-cycle pulses.
module return_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              empty;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign rd_ptr      = wr_ptr_q - PTR_W'(1);
    assign top_o       = mem_q[rd_ptr];
    assign overflow_o  = push_i & full;
    assign underflow_o = pop_i & empty;

    // Entry storage; write slot wraps so a full push lands on the oldest entry.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Write pointer and occupancy; push has priority over pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop_i && !empty) begin
            wr_ptr_q <= rd_ptr;
            count_q  <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: one-hot N-phase cycle generator and program counter with a
// return-address stack, IO-wait pause/resume, halt, and sticky stack flags.
// Optional build macro PC_SEQ_SINGLE_STEP_EN adds step_mode/step_btn: every
// commit then parks in PAUSE until a step_btn rising edge.
//
// state    | meaning
// ST_RUN   | phases advance on step_en; PC updates at commit
// ST_PAUSE | parked at commit; io pause waits for io_ack edge then commits,
//          | single-step pause (commit already done) waits for step_btn edge
// ST_HALT  | frozen until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter int              PHASES      = 4,
    parameter int              INSTR_BYTES = 4,
    parameter int              OFF_SHIFT   = 2,
    parameter int              RAS_DEPTH   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_en,
    output logic [PHASES-1:0] phase,
    input  logic              halt,
    input  logic              io_wait,
    input  logic              io_ack,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
`ifdef PC_SEQ_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_btn,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              paused,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam logic [PHASES-1:0] PH_FIRST = PHASES'(1) << PH_FETCH;

    seq_state_e        state_q;
    logic [PHASES-1:0] phase_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              halted_q;
    logic              paused_q;
    logic              ras_overflow_q;
    logic              ras_underflow_q;
    logic              io_ack_q;

    logic              at_commit;
    logic              io_edge;
    logic              run_commit;
    logic              io_resume;
    logic              commit;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_ovf_pulse;
    logic              ras_unf_pulse;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_delta;

`ifdef PC_SEQ_SINGLE_STEP_EN
    logic              step_pause_q;
    logic              step_btn_q;
    logic              step_edge;
    logic              step_resume;
`endif

    assign at_commit  = phase_q[PHASES-1];
    assign io_edge    = io_ack & ~io_ack_q;
    assign run_commit = (state_q == ST_RUN) & step_en & at_commit & ~halt & ~io_wait;

`ifdef PC_SEQ_SINGLE_STEP_EN
    assign step_edge   = step_btn & ~step_btn_q;
    assign io_resume   = (state_q == ST_PAUSE) & ~step_pause_q & io_edge;
    assign step_resume = (state_q == ST_PAUSE) & step_pause_q & step_edge;
`else
    assign io_resume   = (state_q == ST_PAUSE) & io_edge;
`endif

    assign commit   = run_commit | io_resume;
    // ret outranks call, so a combined call+ret never pushes.
    assign ras_push = commit & call & ~ret;
    assign ras_pop  = commit & ret;

    assign pc_inc   = pc_q + ADDR_W'(INSTR_BYTES);
    assign br_delta = ADDR_W'(sext_shift(MAX_W'(branch_off), ADDR_W, OFF_SHIFT));

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .overflow_o  (ras_ovf_pulse),
        .underflow_o (ras_unf_pulse)
    );

    // PC value loaded at a commit, by control priority.
    always_comb begin
        pc_d = pc_inc;
        if (ret) begin
            pc_d = ras_unf_pulse ? pc_inc : ras_top;
        end else if (call || jump) begin
            pc_d = jump_target;
        end else if (branch) begin
            pc_d = pc_q + br_delta;
        end
    end

    // Sequencer state, phase, PC and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            phase_q         <= PH_FIRST;
            pc_q            <= RESET_PC;
            halted_q        <= 1'b0;
            paused_q        <= 1'b0;
            ras_overflow_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
            io_ack_q        <= 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
            step_pause_q    <= 1'b0;
            step_btn_q      <= 1'b0;
`endif
        end else begin
            io_ack_q <= io_ack;
`ifdef PC_SEQ_SINGLE_STEP_EN
            step_btn_q <= step_btn;
`endif
            if (ras_ovf_pulse) begin
                ras_overflow_q <= 1'b1;
            end
            if (ras_unf_pulse) begin
                ras_underflow_q <= 1'b1;
            end

            case (state_q)
                ST_RUN: begin
                    if (step_en) begin
                        if (!at_commit) begin
                            phase_q <= phase_q << 1;
                        end else if (halt) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else if (io_wait) begin
                            state_q  <= ST_PAUSE;
                            paused_q <= 1'b1;
`ifdef PC_SEQ_SINGLE_STEP_EN
                            step_pause_q <= 1'b0;
`endif
                        end else begin
                            pc_q <= pc_d;
`ifdef PC_SEQ_SINGLE_STEP_EN
                            if (step_mode) begin
                                state_q      <= ST_PAUSE;
                                paused_q     <= 1'b1;
                                step_pause_q <= 1'b1;
                            end else begin
                                phase_q <= PH_FIRST;
                            end
`else
                            phase_q <= PH_FIRST;
`endif
                        end
                    end
                end

                ST_PAUSE: begin
`ifdef PC_SEQ_SINGLE_STEP_EN
                    if (step_resume) begin
                        state_q      <= ST_RUN;
                        paused_q     <= 1'b0;
                        step_pause_q <= 1'b0;
                        phase_q      <= PH_FIRST;
                    end else if (io_resume) begin
                        pc_q <= pc_d;
                        if (step_mode) begin
                            step_pause_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RUN;
                            paused_q <= 1'b0;
                            phase_q  <= PH_FIRST;
                        end
                    end
`else
                    if (io_resume) begin
                        pc_q     <= pc_d;
                        state_q  <= ST_RUN;
                        paused_q <= 1'b0;
                        phase_q  <= PH_FIRST;
                    end
`endif
                end

                ST_HALT: begin
                end

                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign phase         = phase_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign paused        = paused_q;
    assign ras_overflow  = ras_overflow_q;
    assign ras_underflow = ras_underflow_q;

endmodule
